// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared types and constants for the ALU sequencer.
//   seq_state_e : FSM state encoding. These values are also driven on state_o for the LEDs.
//   FLAG_*      : bit positions of the {N,Z,C,V} flags in alu_flags / flags_q.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_LOAD_A = 3'd0,
        S_LOAD_B = 3'd1,
        S_OP     = 3'd2,
        S_EXEC   = 3'd3,
        S_SHOW   = 3'd4
    } seq_state_e;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/edge_detect.sv
// edge_detect
// Rising-edge detector for a level input that is already synchronous to clk.
// While reset is asserted the previous-value register is forced to 1. As a result, an input
// that is held high through reset release does not produce an edge.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-low
//   din  : level input
//   rise : high for the single cycle in which din is high and its previous value was low
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= din;
        end
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Steps a user through loading operand A, operand B and an opcode from switches.
// The sequencer then runs the external ALU for one cycle and latches its result and flags
// for display.
// Optional feature (macro ALU_SEQ_AUTO_STEP_EN):
//   After HOLD_CYCLES cycles in S_SHOW, the opcode is incremented and the same operands
//   are re-executed. Without the macro, S_SHOW is left only on a button event.
// Ports:
//   clk, rst            : clock (rising edge) and synchronous active-low reset
//   sw_data, sw_op      : operand / opcode switches
//   btn_next            : advance button (level, synchronous)
//   alu_a, alu_b, alu_op: registered ALU inputs
//   alu_result, alu_flags: combinational ALU outputs, flags ordered {N,Z,C,V}
//   res_q, flags_q      : latched result and flags for the display path
//   state_o             : current state encoding
//   done                : one-cycle pulse on the cycle res_q/flags_q take new values
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned HOLD_CYCLES = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_data,
    input  logic [3:0]       sw_op,
    input  logic             btn_next,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic [WIDTH-1:0] res_q,
    output logic [3:0]       flags_q,
    output logic [2:0]       state_o,
    output logic             done
);

    seq_state_e state_q;
    logic       adv;

    edge_detect u_edge_detect (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_next),
        .rise (adv)
    );

`ifdef ALU_SEQ_AUTO_STEP_EN
    localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    logic [CNT_W-1:0] hold_cnt;
    logic             hold_expired;

    assign hold_expired = (hold_cnt == CNT_W'(HOLD_CYCLES - 1));
`else
    // HOLD_CYCLES has no effect in this build.
    logic unused_hold;
    assign unused_hold = ^HOLD_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_LOAD_A;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            res_q   <= '0;
            flags_q <= '0;
            done    <= 1'b0;
`ifdef ALU_SEQ_AUTO_STEP_EN
            hold_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef ALU_SEQ_AUTO_STEP_EN
            // The counter only runs in S_SHOW, so it is zero whenever S_SHOW is entered.
            hold_cnt <= '0;
`endif
            case (state_q)
                S_LOAD_A: begin
                    if (adv) begin
                        alu_a   <= sw_data;
                        state_q <= S_LOAD_B;
                    end
                end
                S_LOAD_B: begin
                    if (adv) begin
                        alu_b   <= sw_data;
                        state_q <= S_OP;
                    end
                end
                S_OP: begin
                    if (adv) begin
                        alu_op  <= sw_op;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Operands have been stable for this whole cycle, so alu_result is valid.
                    res_q   <= alu_result;
                    flags_q <= alu_flags;
                    done    <= 1'b1;
                    state_q <= S_SHOW;
                end
                S_SHOW: begin
`ifdef ALU_SEQ_AUTO_STEP_EN
                    // A button event takes priority over a hold expiry in the same cycle.
                    if (adv) begin
                        state_q <= S_LOAD_A;
                    end else if (hold_expired) begin
                        alu_op  <= alu_op + 4'd1;
                        state_q <= S_EXEC;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
`else
                    if (adv) begin
                        state_q <= S_LOAD_A;
                    end
`endif
                end
                default: state_q <= S_LOAD_A;
            endcase
        end
    end

    assign state_o = state_q;

endmodule
